// File: rtl/frame_sequencer_pkg.sv
// apu_pkg: constants and types shared by the APU frame sequencer.
//   FRAME_DIVIDER : APU clocks per sequencer step (1.789773 MHz / 240 Hz)
//   MODE_BIT      : $4017 bit selecting 5-step mode
//   INHIBIT_BIT   : $4017 bit inhibiting the frame IRQ
//   step_t        : sequencer step encodings STEP0..STEP4
//   last_step()   : final step of the sequence for a given mode
package apu_pkg;

    localparam int FRAME_DIVIDER = 7457;
    localparam int MODE_BIT      = 7;
    localparam int INHIBIT_BIT   = 6;

    typedef enum logic [2:0] {
        STEP0 = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        STEP4 = 3'd4
    } step_t;

    // 4-step mode wraps after STEP3, 5-step mode after STEP4.
    function automatic step_t last_step(input logic five_step);
        return five_step ? STEP4 : STEP3;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: register-side and channel-side signals of the frame
// sequencer.
//   reg_4017     : frame register value ([7]=mode, [6]=IRQ inhibit)
//   reg_event    : one-cycle strobe, reg_4017 was just written
//   status_read  : one-cycle strobe, $4015 read (clears frame IRQ)
//   enable_240hz : quarter-frame strobe
//   enable_120hz : half-frame strobe
//   frame_irq    : frame interrupt flag (level)
// master = CPU/register side driving the strobes, slave = the sequencer.
interface frame_sequencer_if;

    logic [7:0] reg_4017;
    logic       reg_event;
    logic       status_read;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       frame_irq;

    modport master (
        output reg_4017,
        output reg_event,
        output status_read,
        input  enable_240hz,
        input  enable_120hz,
        input  frame_irq
    );

    modport slave (
        input  reg_4017,
        input  reg_event,
        input  status_read,
        output enable_240hz,
        output enable_120hz,
        output frame_irq
    );

endinterface

// File: rtl/frame_sequencer_prescaler.sv
// frame_prescaler: modulo-N counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (count -> 0)
//   clear : synchronous clear to 0, overrides counting
//   tc    : high while count == N-1 (terminal count)
module frame_prescaler
    import apu_pkg::*;
#(
    parameter int N = FRAME_DIVIDER,
    parameter int W = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    logic [W-1:0] count;

    assign tc = (count == W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: APU frame counter. Divides the APU clock into one-cycle
// quarter-frame (~240 Hz) and half-frame (~120 Hz) strobes, implements the
// $4017 4-step / 5-step modes and the frame IRQ flag.
//   clk : APU clock, rising edge
//   rst : asynchronous active-high reset
//   bus : frame_sequencer_if.slave (register inputs, strobes, frame_irq)
module frame_sequencer
    import apu_pkg::*;
#(
    parameter int DIVIDER = FRAME_DIVIDER,
    parameter int DIV_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    frame_sequencer_if.slave  bus
);

    logic  tc;
    step_t step;
    logic  mode_q;
    logic  inhibit_q;
    logic  quarter;
    logic  half;
    logic  irq_set;
    logic  write_mode;
    logic  write_inhibit;

    logic  enable_240hz;
    logic  enable_120hz;
    logic  frame_irq;

    // Quarter-frame strobe decode: every step except the silent 5-step step 3.
    function automatic logic quarter_on(input logic five_step, input step_t s);
        return five_step ? (s != STEP3) : 1'b1;
    endfunction

    // Half-frame strobe decode: steps 1 and the last step of the sequence.
    function automatic logic half_on(input logic five_step, input step_t s);
        return five_step ? (s == STEP1 || s == STEP4) : (s == STEP1 || s == STEP3);
    endfunction

    frame_prescaler #(
        .N (DIVIDER),
        .W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.reg_event),
        .tc    (tc)
    );

    assign write_mode    = bus.reg_4017[MODE_BIT];
    assign write_inhibit = bus.reg_4017[INHIBIT_BIT];
    assign quarter       = quarter_on(mode_q, step);
    assign half          = half_on(mode_q, step);

    // A register write on the TC cycle restarts the sequence, so the step-3
    // IRQ set is suppressed along with the step strobes.
    assign irq_set = tc && !bus.reg_event && !mode_q && !inhibit_q && (step == STEP3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step         <= STEP0;
            mode_q       <= 1'b0;
            inhibit_q    <= 1'b0;
            enable_240hz <= 1'b0;
            enable_120hz <= 1'b0;
            frame_irq    <= 1'b0;
        end else begin
            enable_240hz <= 1'b0;
            enable_120hz <= 1'b0;

            if (bus.reg_event) begin
                mode_q       <= write_mode;
                inhibit_q    <= write_inhibit;
                step         <= STEP0;
                // Writing 5-step mode clocks the channels immediately.
                enable_240hz <= write_mode;
                enable_120hz <= write_mode;
            end else if (tc) begin
                // Strobes come from the step being left, not the one entered.
                enable_240hz <= quarter;
                enable_120hz <= half;
                step         <= (step == last_step(mode_q)) ? STEP0 : step_t'(step + 3'd1);
            end

            // Priority: inhibit write clears, then step-3 set, then status read clears.
            if (bus.reg_event && write_inhibit) begin
                frame_irq <= 1'b0;
            end else if (irq_set) begin
                frame_irq <= 1'b1;
            end else if (bus.status_read) begin
                frame_irq <= 1'b0;
            end
        end
    end

    assign bus.enable_240hz = enable_240hz;
    assign bus.enable_120hz = enable_120hz;
    assign bus.frame_irq    = frame_irq;

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: a DIVIDER=4 instance exercised by a table,
// directed corner-case sequences and random stimulus against a timeline-based
// reference model, plus a DIVIDER=7457 instance measuring the strobe period.
module tb_frame_sequencer;

    localparam int D     = 4;
    localparam int BIG_D = 7457;

    logic clk;
    logic rst;
    logic rst_big;

    int checks;
    int errors;
    bit smoke_done;

    frame_sequencer_if bus ();
    frame_sequencer_if bus_big ();

    frame_sequencer #(.DIVIDER(D), .DIV_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    frame_sequencer #(.DIVIDER(BIG_D), .DIV_W(13)) dut_big (
        .clk (clk),
        .rst (rst_big),
        .bus (bus_big)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: elapsed edges since the last restart (reset release or
    // $4017 write) determine the step position arithmetically.
    longint m_t;
    bit     m_mode;
    bit     m_inh;
    bit     m_irq;
    bit     m_e240;
    bit     m_e120;

    typedef struct {
        logic [7:0] r;
        bit         ev;
        bit         sr;
        bit         e240;
        bit         e120;
        bit         eirq;
    } vec_t;

    vec_t tbl [17];

    function automatic void chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_t    = 0;
        m_mode = 0;
        m_inh  = 0;
        m_irq  = 0;
        m_e240 = 0;
        m_e120 = 0;
    endfunction

    function automatic void model_edge(input logic [7:0] r, input bit ev, input bit sr);
        bit set;
        int s;
        set    = 0;
        m_e240 = 0;
        m_e120 = 0;
        if (ev) begin
            m_t    = 0;
            m_mode = r[7];
            m_inh  = r[6];
            m_e240 = r[7];
            m_e120 = r[7];
        end else begin
            m_t++;
            if (m_t % D == 0) begin
                s = int'(((m_t / D) - 1) % (m_mode ? 5 : 4));
                if (m_mode) begin
                    m_e240 = (s != 3);
                    m_e120 = (s == 1 || s == 4);
                end else begin
                    m_e240 = 1;
                    m_e120 = (s == 1 || s == 3);
                    set    = !m_inh && (s == 3);
                end
            end
        end
        if (ev && r[6])   m_irq = 0;
        else if (set)     m_irq = 1;
        else if (sr)      m_irq = 0;
    endfunction

    // Called at a negedge: apply inputs, take one rising edge, compare at the
    // following negedge against the model.
    task automatic step_cycle(input logic [7:0] r, input bit ev, input bit sr);
        bus.reg_4017    = r;
        bus.reg_event   = ev;
        bus.status_read = sr;
        @(posedge clk);
        model_edge(r, ev, sr);
        @(negedge clk);
        bus.reg_event   = 1'b0;
        bus.status_read = 1'b0;
        chk("model_240", bus.enable_240hz, m_e240);
        chk("model_120", bus.enable_120hz, m_e120);
        chk("model_irq", bus.frame_irq, m_irq);
    endtask

    task automatic idle_until_tc_next();
        // Advance until the next edge is a prescaler terminal-count edge.
        for (int n = 0; n < 4 * D && ((m_t + 1) % D) != 0; n++) step_cycle(8'h00, 0, 0);
    endtask

    // DIVIDER=7457 smoke run: first strobe and period of the 240 Hz output.
    initial begin
        int seen [3];
        int nseen;
        nseen               = 0;
        rst_big             = 1'b1;
        bus_big.reg_4017    = 8'h00;
        bus_big.reg_event   = 1'b0;
        bus_big.status_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_big = 1'b0;
        for (int cyc = 1; cyc <= 3 * BIG_D + 100 && nseen < 3; cyc++) begin
            @(negedge clk);
            if (bus_big.enable_240hz) begin
                seen[nseen] = cyc;
                nseen++;
            end
        end
        if (nseen < 3) begin
            checks++;
            errors++;
            $display("FAIL smoke_strobes got %0d strobes expected 3", nseen);
        end else begin
            checks += 3;
            if (seen[0] != BIG_D) begin
                errors++;
                $display("FAIL smoke_first got %0d expected %0d", seen[0], BIG_D);
            end
            if (seen[1] - seen[0] != BIG_D) begin
                errors++;
                $display("FAIL smoke_period1 got %0d expected %0d", seen[1] - seen[0], BIG_D);
            end
            if (seen[2] - seen[1] != BIG_D) begin
                errors++;
                $display("FAIL smoke_period2 got %0d expected %0d", seen[2] - seen[1], BIG_D);
            end
        end
        smoke_done = 1'b1;
    end

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.reg_4017    = 8'h00;
        bus.reg_event   = 1'b0;
        bus.status_read = 1'b0;
        model_reset();

        // Test 1 expectations straight from the cycle numbers.
        for (int i = 0; i < 17; i++) begin
            tbl[i].r    = 8'h00;
            tbl[i].ev   = 0;
            tbl[i].sr   = 0;
            tbl[i].e240 = ((i + 1) inside {4, 8, 12, 16});
            tbl[i].e120 = ((i + 1) inside {8, 16});
            tbl[i].eirq = ((i + 1) >= 16);
        end

        repeat (3) @(negedge clk);
        chk("reset_240", bus.enable_240hz, 1'b0);
        chk("reset_120", bus.enable_120hz, 1'b0);
        chk("reset_irq", bus.frame_irq, 1'b0);
        rst = 1'b0;

        // Test 1: 4-step free run from reset.
        for (int i = 0; i < 17; i++) begin
            step_cycle(tbl[i].r, tbl[i].ev, tbl[i].sr);
            chk($sformatf("t1_240_c%0d", i + 1), bus.enable_240hz, tbl[i].e240);
            chk($sformatf("t1_120_c%0d", i + 1), bus.enable_120hz, tbl[i].e120);
            chk($sformatf("t1_irq_c%0d", i + 1), bus.frame_irq, tbl[i].eirq);
        end

        // Test 2: status read clears; status read on the step-3 TC loses to set.
        step_cycle(8'h00, 0, 1);
        chk("t2_clear", bus.frame_irq, 1'b0);
        for (int n = 0; n < 4 * 4 * D && ((m_t + 1) % (4 * D)) != 0; n++) step_cycle(8'h00, 0, 0);
        chk("t2_pre_set", bus.frame_irq, 1'b0);
        step_cycle(8'h00, 0, 1);
        chk("t2_set_wins", bus.frame_irq, 1'b1);

        // Test 3: 5-step write with immediate clock, no IRQ.
        step_cycle(8'h00, 0, 1);
        step_cycle(8'h80, 1, 0);
        chk("t3_imm_240", bus.enable_240hz, 1'b1);
        chk("t3_imm_120", bus.enable_120hz, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            step_cycle(8'h00, 0, 0);
            if (k <= 20) begin
                chk($sformatf("t3_240_+%0d", k), bus.enable_240hz, (k % 4 == 0) && (k != 16));
                chk($sformatf("t3_120_+%0d", k), bus.enable_120hz, (k == 8) || (k == 20));
            end
            chk($sformatf("t3_irq_+%0d", k), bus.frame_irq, 1'b0);
        end

        // Test 4: inhibit write clears a pending IRQ and keeps it clear.
        step_cycle(8'h00, 1, 0);
        repeat (16) step_cycle(8'h00, 0, 0);
        chk("t4_irq_set", bus.frame_irq, 1'b1);
        step_cycle(8'h40, 1, 0);
        chk("t4_inhibit_clear", bus.frame_irq, 1'b0);
        for (int k = 1; k <= 3 * 4 * D; k++) begin
            step_cycle(8'h00, 0, 0);
            chk($sformatf("t4_irq_+%0d", k), bus.frame_irq, 1'b0);
        end

        // Test 5: write on a TC cycle suppresses that cycle's step strobe.
        idle_until_tc_next();
        step_cycle(8'h00, 1, 0);
        chk("t5_no_strobe", bus.enable_240hz, 1'b0);
        for (int k = 1; k <= D; k++) begin
            step_cycle(8'h00, 0, 0);
            chk($sformatf("t5_240_+%0d", k), bus.enable_240hz, k == D);
        end

        // Test 6: async reset at step 2 / prescaler 1 with the IRQ pending.
        for (int n = 0; n < 8 * D && m_t < 16; n++) step_cycle(8'h00, 0, 0);
        chk("t6_irq_before", bus.frame_irq, 1'b1);
        for (int n = 0; n < 8 * D && (m_t % (4 * D)) != (2 * D + 1); n++) step_cycle(8'h00, 0, 0);
        rst = 1'b1;
        #1;
        chk("t6_async_240", bus.enable_240hz, 1'b0);
        chk("t6_async_120", bus.enable_120hz, 1'b0);
        chk("t6_async_irq", bus.frame_irq, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= D; k++) begin
            step_cycle(8'h00, 0, 0);
            chk($sformatf("t6_240_+%0d", k), bus.enable_240hz, k == D);
        end

        // Random traffic: register noise, occasional writes and status reads.
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] r;
            bit ev;
            bit sr;
            r  = 8'($urandom);
            ev = ($urandom_range(0, 39) == 0);
            sr = ($urandom_range(0, 19) == 0);
            step_cycle(r, ev, sr);
            if (bus.enable_120hz && !bus.enable_240hz) chk("rand_120_implies_240", 1'b0, 1'b1);
        end

        for (int n = 0; n < 30000 && !smoke_done; n++) @(negedge clk);
        if (!smoke_done) chk("smoke_timeout", 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
